freelist_ckpt: RTL and testbench

N-wide allocator for physical register tags or issue-queue entries, a parametrised successor to the two-wide freelist. It sits in rename/dispatch. Each cycle it grants up to ALLOC_W free tags all-or-nothing and accepts up to REL_W released tags from commit or issue. It keeps CKPT_NUM free-bit snapshots so a branch misprediction restores the freelist in one cycle.

---
 rtl/freelist_ckpt_if.sv | 38 +++
 rtl/freelist_ckpt.sv | 195 +++++++++++++++++++
 tb/tb_freelist_ckpt.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/freelist_ckpt_if.sv
// Signal bundle between rename/dispatch and the checkpointed freelist:
// allocation grants, tag releases, checkpoint take/free and misprediction recovery.
interface freelist_ckpt_if #(
    parameter int FREE_SEL = 6,
    parameter int ALLOC_W  = 2,
    parameter int REL_W    = 2,
    parameter int CKPT_NUM = 4,
    parameter int CKPT_SEL = 2
);
    logic [ALLOC_W-1:0]          req_valid;
    logic                        stall;
    logic [ALLOC_W*FREE_SEL-1:0] alloc_tag;
    logic [ALLOC_W-1:0]          alloc_valid;
    logic                        alloc_ok;
    logic [REL_W-1:0]            rel_valid;
    logic [REL_W*FREE_SEL-1:0]   rel_tag;
    logic                        ckpt_take;
    logic [CKPT_SEL-1:0]         ckpt_id;
    logic                        ckpt_avail;
    logic                        ckpt_done_valid;
    logic [CKPT_SEL-1:0]         ckpt_done_id;
    logic                        recover;
    logic [CKPT_SEL-1:0]         recover_id;
    logic [CKPT_NUM-1:0]         recover_kill;
    logic [FREE_SEL:0]           free_count;

    modport master (
        output req_valid, stall, rel_valid, rel_tag, ckpt_take,
               ckpt_done_valid, ckpt_done_id, recover, recover_id, recover_kill,
        input  alloc_tag, alloc_valid, alloc_ok, ckpt_id, ckpt_avail, free_count
    );

    modport slave (
        input  req_valid, stall, rel_valid, rel_tag, ckpt_take,
               ckpt_done_valid, ckpt_done_id, recover, recover_id, recover_kill,
        output alloc_tag, alloc_valid, alloc_ok, ckpt_id, ckpt_avail, free_count
    );
endinterface

// File: rtl/freelist_ckpt.sv
// N-wide all-or-nothing tag allocator with per-branch free-bit snapshots so a
// misprediction restores the freelist in a single cycle.
module freelist_ckpt #(
    parameter int FREE_NUM = 64,
    parameter int FREE_SEL = 6,
    parameter int ALLOC_W  = 2,
    parameter int REL_W    = 2,
    parameter int RESV_NUM = 32,
    parameter int CKPT_NUM = 4,
    parameter int CKPT_SEL = 2
) (
    input  logic           clk,
    input  logic           reset,
    freelist_ckpt_if.slave bus
);
    localparam int CW = FREE_SEL + 1;
    localparam logic [CW-1:0] RESET_COUNT = CW'(FREE_NUM - RESV_NUM);

    typedef logic [FREE_NUM-1:0] fmask_t;

    function automatic logic [CW-1:0] popcount_free(input fmask_t v);
        logic [CW-1:0] c;
        c = {CW{1'b0}};
        for (int i = 0; i < FREE_NUM; i++) begin
            c = c + {{FREE_SEL{1'b0}}, v[i]};
        end
        return c;
    endfunction

    function automatic logic [CW-1:0] popcount_req(input logic [ALLOC_W-1:0] v);
        logic [CW-1:0] c;
        c = {CW{1'b0}};
        for (int i = 0; i < ALLOC_W; i++) begin
            c = c + {{FREE_SEL{1'b0}}, v[i]};
        end
        return c;
    endfunction

    function automatic fmask_t reset_mask();
        fmask_t m;
        for (int i = 0; i < FREE_NUM; i++) begin
            m[i] = (i >= RESV_NUM);
        end
        return m;
    endfunction

    fmask_t                  free_q, free_d;
    fmask_t                  snap_q [CKPT_NUM];
    fmask_t                  snap_d [CKPT_NUM];
    logic [CKPT_NUM-1:0]     snap_valid_q, snap_valid_d;
    logic [CW-1:0]           count_q, count_d;

    logic [CW-1:0]           reqnum_s;
    logic                    alloc_ok_s;
    logic [ALLOC_W-1:0]      alloc_valid_s;
    logic [ALLOC_W*FREE_SEL-1:0] alloc_tag_s;
    fmask_t                  grant_mask_s;
    fmask_t                  rel_mask_s;
    logic [CKPT_SEL-1:0]     ckpt_id_s;
    logic                    ckpt_avail_s;
    logic                    take_fire_s;

    assign reqnum_s   = popcount_req(bus.req_valid);
    assign alloc_ok_s = reset & ~bus.stall & ~bus.recover
                      & (count_q >= reqnum_s) & (reqnum_s != {CW{1'b0}});

    // Each requesting channel, in ascending order, takes the lowest tag still free.
    always_comb begin
        fmask_t              avail;
        logic                found;
        logic [FREE_SEL-1:0] pick;
        avail         = free_q;
        grant_mask_s  = {FREE_NUM{1'b0}};
        alloc_valid_s = {ALLOC_W{1'b0}};
        alloc_tag_s   = {(ALLOC_W*FREE_SEL){1'b0}};
        for (int k = 0; k < ALLOC_W; k++) begin
            found = 1'b0;
            pick  = {FREE_SEL{1'b0}};
            for (int i = 0; i < FREE_NUM; i++) begin
                if (!found && avail[i]) begin
                    found = 1'b1;
                    pick  = FREE_SEL'(i);
                end else begin
                    found = found;
                end
            end
            if (alloc_ok_s && bus.req_valid[k] && found) begin
                alloc_valid_s[k]                     = 1'b1;
                alloc_tag_s[k*FREE_SEL +: FREE_SEL]  = pick;
                avail[pick]                          = 1'b0;
                grant_mask_s[pick]                   = 1'b1;
            end else begin
                alloc_valid_s[k] = 1'b0;
            end
        end
    end

    // Decode the release channels into a bit mask.
    always_comb begin
        rel_mask_s = {FREE_NUM{1'b0}};
        for (int r = 0; r < REL_W; r++) begin
            if (bus.rel_valid[r]) begin
                rel_mask_s[bus.rel_tag[r*FREE_SEL +: FREE_SEL]] = 1'b1;
            end else begin
                rel_mask_s = rel_mask_s;
            end
        end
    end

    // Lowest invalid snapshot slot; reset forces an available slot 0.
    always_comb begin
        logic found;
        found     = 1'b0;
        ckpt_id_s = {CKPT_SEL{1'b0}};
        for (int c = CKPT_NUM - 1; c >= 0; c--) begin
            if (!snap_valid_q[c]) begin
                found     = 1'b1;
                ckpt_id_s = CKPT_SEL'(c);
            end else begin
                found = found;
            end
        end
        if (!reset) begin
            ckpt_id_s    = {CKPT_SEL{1'b0}};
            ckpt_avail_s = 1'b1;
        end else begin
            ckpt_avail_s = found;
        end
    end

    assign take_fire_s = reset & bus.ckpt_take & ckpt_avail_s & ~bus.recover;

    // Next free bits and count; recovery takes the snapshot plus this cycle's releases.
    always_comb begin
        if (bus.recover) begin
            free_d = snap_q[bus.recover_id] | rel_mask_s;
        end else begin
            free_d = (free_q | rel_mask_s) & ~grant_mask_s;
        end
        count_d = popcount_free(free_d);
    end

    // Snapshots absorb releases so a restore keeps commits made after the branch.
    always_comb begin
        for (int c = 0; c < CKPT_NUM; c++) begin
            if (take_fire_s && (ckpt_id_s == CKPT_SEL'(c))) begin
                snap_d[c] = free_d;
            end else if (snap_valid_q[c]) begin
                snap_d[c] = snap_q[c] | rel_mask_s;
            end else begin
                snap_d[c] = snap_q[c];
            end
        end
        if (bus.recover) begin
            snap_valid_d = snap_valid_q & ~bus.recover_kill;
        end else begin
            snap_valid_d = snap_valid_q;
            if (bus.ckpt_done_valid) begin
                snap_valid_d[bus.ckpt_done_id] = 1'b0;
            end else begin
                snap_valid_d = snap_valid_d;
            end
            if (take_fire_s) begin
                snap_valid_d[ckpt_id_s] = 1'b1;
            end else begin
                snap_valid_d = snap_valid_d;
            end
        end
    end

    // Freelist, count and snapshot-valid registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            free_q       <= reset_mask();
            count_q      <= RESET_COUNT;
            snap_valid_q <= {CKPT_NUM{1'b0}};
        end else begin
            free_q       <= free_d;
            count_q      <= count_d;
            snap_valid_q <= snap_valid_d;
        end
    end

    // Snapshot contents are only meaningful while their valid bit is set.
    always_ff @(posedge clk) begin
        snap_q <= snap_d;
    end

    assign bus.alloc_tag   = alloc_tag_s;
    assign bus.alloc_valid = alloc_valid_s;
    assign bus.alloc_ok    = alloc_ok_s;
    assign bus.ckpt_id     = ckpt_id_s;
    assign bus.ckpt_avail  = ckpt_avail_s;
    assign bus.free_count  = count_q;
endmodule

// File: tb/tb_freelist_ckpt.sv
// Bench for freelist_ckpt: set/queue reference model compared every cycle, plus
// hand-computed literal checks along the directed scenarios.
module tb_freelist_ckpt;
    localparam int FN = 64, FS = 6, AW = 2, RW = 2, RN = 32, CN = 4, CS = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    freelist_ckpt_if #(.FREE_SEL(FS), .ALLOC_W(AW), .REL_W(RW), .CKPT_NUM(CN), .CKPT_SEL(CS)) bus();

    freelist_ckpt #(.FREE_NUM(FN), .FREE_SEL(FS), .ALLOC_W(AW), .REL_W(RW),
                    .RESV_NUM(RN), .CKPT_NUM(CN), .CKPT_SEL(CS)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    bit mfree [FN];
    bit msnap [CN][FN];
    bit msv   [CN];
    bit mready = 1'b0;

    bit          e_ok;
    bit [AW-1:0] e_av;
    int          e_tag [AW];
    bit [FN-1:0] e_grant;
    bit          e_avail;
    int          e_id;
    int          e_cnt;

    task automatic check(string name, longint act, longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int mcount();
        int n = 0;
        for (int i = 0; i < FN; i++) n += int'(mfree[i]);
        return n;
    endfunction

    // Expected outputs from the set of free tags: grants pop the sorted free queue.
    function automatic void model_eval();
        int q[$];
        int rq;
        e_ok = 1'b0; e_av = '0; e_grant = '0; e_avail = 1'b1; e_id = 0;
        for (int k = 0; k < AW; k++) e_tag[k] = 0;
        for (int i = 0; i < FN; i++) if (mfree[i]) q.push_back(i);
        e_cnt = q.size();
        if (reset == 1'b0) return;
        rq = $countones(bus.req_valid);
        e_ok = !bus.stall && !bus.recover && rq != 0 && q.size() >= rq;
        if (e_ok) begin
            for (int k = 0; k < AW; k++) begin
                if (bus.req_valid[k]) begin
                    e_av[k]  = 1'b1;
                    e_tag[k] = q.pop_front();
                    e_grant[e_tag[k]] = 1'b1;
                end
            end
        end
        e_avail = 1'b0;
        for (int c = CN - 1; c >= 0; c--) begin
            if (!msv[c]) begin e_avail = 1'b1; e_id = c; end
        end
    endfunction

    // Compare process: every cycle on the falling edge.
    always @(negedge clk) begin
        model_eval();
        check("alloc_ok", bus.alloc_ok, e_ok);
        check("alloc_valid", bus.alloc_valid, e_av);
        for (int k = 0; k < AW; k++)
            if (e_av[k]) check("alloc_tag", bus.alloc_tag[k*FS +: FS], e_tag[k]);
        check("ckpt_avail", bus.ckpt_avail, e_avail);
        if (e_avail) check("ckpt_id", bus.ckpt_id, e_id);
        if (mready) check("free_count", bus.free_count, e_cnt);
    end

    // Model state update on the rising edge.
    always @(posedge clk) begin
        bit [FN-1:0] rel;
        bit nf [FN];
        int t;
        model_eval();
        if (reset == 1'b0) begin
            for (int i = 0; i < FN; i++) mfree[i] = (i >= RN);
            for (int c = 0; c < CN; c++) msv[c] = 1'b0;
            mready = 1'b1;
        end else begin
            rel = '0;
            for (int r = 0; r < RW; r++) begin
                if (bus.rel_valid[r]) begin
                    t = int'(bus.rel_tag[r*FS +: FS]);
                    check("legal_release", int'(mfree[t]), 0);
                    rel[t] = 1'b1;
                end
            end
            if (bus.recover) check("legal_recover", int'(msv[bus.recover_id]), 1);
            for (int i = 0; i < FN; i++)
                nf[i] = bus.recover ? (msnap[bus.recover_id][i] | rel[i])
                                    : ((mfree[i] | rel[i]) & !e_grant[i]);
            for (int c = 0; c < CN; c++)
                if (msv[c]) for (int i = 0; i < FN; i++) msnap[c][i] |= rel[i];
            if (bus.recover) begin
                for (int c = 0; c < CN; c++) if (bus.recover_kill[c]) msv[c] = 1'b0;
            end else begin
                if (bus.ckpt_done_valid) msv[bus.ckpt_done_id] = 1'b0;
                if (bus.ckpt_take && e_avail) begin
                    msnap[e_id] = nf;
                    msv[e_id]   = 1'b1;
                end
            end
            mfree = nf;
        end
    end

    task automatic clr();
        bus.req_valid = '0; bus.stall = 1'b0; bus.rel_valid = '0; bus.rel_tag = '0;
        bus.ckpt_take = 1'b0; bus.ckpt_done_valid = 1'b0; bus.ckpt_done_id = '0;
        bus.recover = 1'b0; bus.recover_id = '0; bus.recover_kill = '0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
        clr();
    endtask

    task automatic rel(int ch, int tag);
        bus.rel_valid[ch] = 1'b1;
        bus.rel_tag[ch*FS +: FS] = FS'(tag);
    endtask

    initial begin
        clr();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        check("lit_reset_count", bus.free_count, 32);

        bus.req_valid = 2'b11; #1;
        check("lit_tag0_32", bus.alloc_tag[FS-1:0], 32);
        check("lit_tag1_33", bus.alloc_tag[2*FS-1:FS], 33);
        check("lit_ok_first", bus.alloc_ok, 1);
        tick();
        check("lit_count_30", bus.free_count, 30);

        repeat (14) begin bus.req_valid = 2'b11; tick(); end
        bus.req_valid = 2'b01; tick();
        check("lit_count_1", bus.free_count, 1);
        bus.req_valid = 2'b11; #1;
        check("lit_short_ok", bus.alloc_ok, 0);
        check("lit_short_valid", bus.alloc_valid, 0);
        tick();
        check("lit_count_still_1", bus.free_count, 1);
        bus.req_valid = 2'b10; #1;
        check("lit_ch1_valid", bus.alloc_valid, 2);
        check("lit_ch1_tag63", bus.alloc_tag[2*FS-1:FS], 63);
        tick();
        check("lit_empty", bus.free_count, 0);

        rel(0, 5); bus.req_valid = 2'b01; #1;
        check("lit_no_bypass", bus.alloc_ok, 0);
        tick();
        bus.req_valid = 2'b01; #1;
        check("lit_rel5_ok", bus.alloc_ok, 1);
        check("lit_rel5_tag", bus.alloc_tag[FS-1:0], 5);
        tick();

        rel(0, 40); rel(1, 41); tick();
        rel(0, 42); rel(1, 43); tick();
        rel(0, 44); rel(1, 45); tick();
        check("lit_count_6", bus.free_count, 6);
        bus.req_valid = 2'b11; bus.ckpt_take = 1'b1; #1;
        check("lit_ck_tag40", bus.alloc_tag[FS-1:0], 40);
        check("lit_ck_tag41", bus.alloc_tag[2*FS-1:FS], 41);
        check("lit_ck_id0", bus.ckpt_id, 0);
        tick();
        bus.req_valid = 2'b11; tick();
        bus.req_valid = 2'b11; rel(0, 3); tick();
        check("lit_pre_recover", bus.free_count, 1);
        bus.recover = 1'b1; bus.recover_id = 2'd0; bus.recover_kill = 4'b0001; tick();
        check("lit_post_recover", bus.free_count, 5);
        check("lit_slot0_freed", bus.ckpt_id, 0);
        bus.req_valid = 2'b11; #1;
        check("lit_restored_tag3", bus.alloc_tag[FS-1:0], 3);
        check("lit_restored_tag42", bus.alloc_tag[2*FS-1:FS], 42);
        clr();

        for (int i = 0; i < CN; i++) begin
            bus.ckpt_take = 1'b1; #1;
            check("lit_take_id", bus.ckpt_id, i);
            tick();
        end
        check("lit_full_ckpt", bus.ckpt_avail, 0);
        bus.ckpt_done_valid = 1'b1; bus.ckpt_done_id = 2'd2; tick();
        check("lit_avail_again", bus.ckpt_avail, 1);
        bus.ckpt_take = 1'b1; #1;
        check("lit_reuse_id2", bus.ckpt_id, 2);
        tick();
        check("lit_full_again", bus.ckpt_avail, 0);

        bus.recover = 1'b1; bus.recover_id = 2'd1; bus.recover_kill = 4'b1110;
        bus.req_valid = 2'b11; bus.ckpt_take = 1'b1; rel(0, 7); #1;
        check("lit_rec_no_ok", bus.alloc_ok, 0);
        check("lit_rec_no_valid", bus.alloc_valid, 0);
        tick();
        check("lit_rec_count", bus.free_count, 6);
        check("lit_rec_id1", bus.ckpt_id, 1);
        bus.req_valid = 2'b11; #1;
        check("lit_rec_tag3", bus.alloc_tag[FS-1:0], 3);
        check("lit_rec_tag7", bus.alloc_tag[2*FS-1:FS], 7);
        clr();

        for (int guard = 0; guard < 100 && mcount() < FN; guard++) begin
            int n;
            n = 0;
            for (int t = 0; t < FN && n < RW; t++)
                if (!mfree[t]) begin rel(n, t); n++; end
            tick();
        end
        check("lit_full_list", bus.free_count, 64);
        bus.req_valid = 2'b11; #1;
        check("lit_full_tag0", bus.alloc_tag[FS-1:0], 0);
        check("lit_full_tag1", bus.alloc_tag[2*FS-1:FS], 1);
        tick();

        for (int cyc = 0; cyc < 400; cyc++) begin
            int t, s;
            bit any_free_slot;
            bus.req_valid = AW'($urandom_range(0, 3));
            bus.stall = ($urandom_range(0, 7) == 0);
            for (int r = 0; r < RW; r++) begin
                t = $urandom_range(0, FN - 1);
                if ($urandom_range(0, 1) == 1 && !mfree[t] &&
                    !(r == 1 && bus.rel_valid[0] && bus.rel_tag[FS-1:0] == FS'(t)))
                    rel(r, t);
            end
            any_free_slot = 1'b0;
            for (int c = 0; c < CN; c++) if (!msv[c]) any_free_slot = 1'b1;
            if (any_free_slot && $urandom_range(0, 2) == 0) bus.ckpt_take = 1'b1;
            s = $urandom_range(0, CN - 1);
            if (msv[s] && $urandom_range(0, 3) == 0) begin
                bus.ckpt_done_valid = 1'b1; bus.ckpt_done_id = CS'(s);
            end
            s = $urandom_range(0, CN - 1);
            if (msv[s] && $urandom_range(0, 9) == 0) begin
                bus.recover = 1'b1; bus.recover_id = CS'(s);
                bus.recover_kill = CN'($urandom_range(0, 15)) | (CN'(1) << s);
            end
            tick();
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
